// File: rtl/sw_pkg.sv
// sw_pkg: shared clause type, switch default sizes and a small modulo helper.
package sw_pkg;

   localparam int unsigned CLA_W = 32;
   typedef logic [CLA_W-1:0] cla_t;

   localparam int unsigned SW_DEF_FIFO_DEPTH = 4;
   localparam int unsigned SW_DEF_NUM_ENG    = 4;

   // (base + offset) mod n, valid for base < n and offset <= n.
   function automatic int unsigned rr_index(int unsigned base, int unsigned offset,
                                            int unsigned n);
      int unsigned s;
      s = base + offset;
      return (s >= n) ? s - n : s;
   endfunction

endpackage

// File: rtl/sw_fifo.sv
// sw_fifo: synchronous FIFO of cla_t. Push and pop may coincide when full.
// Head reads as zero while empty so the output is clean out of reset.
module sw_fifo
   import sw_pkg::*;
#(
   parameter int unsigned Depth = SW_DEF_FIFO_DEPTH
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  cla_t                   din_i,
   output cla_t                   dout_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic [$clog2(Depth):0] count_o
);

   localparam int unsigned PtrW = $clog2(Depth);

   cla_t            mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]   count_q, count_d;
   logic            push_en, pop_en;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (PtrW + 1)'(Depth));
   assign count_o = count_q;
   assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   // A full FIFO accepts a push only alongside a pop; an empty one never pops.
   assign pop_en  = pop_i & ~empty_o;
   assign push_en = push_i & (~full_o | pop_en);

   // Occupancy next-state.
   always_comb begin
      count_d = count_q;
      unique case ({push_en, pop_en})
         2'b10:   count_d = count_q + (PtrW + 1)'(1);
         2'b01:   count_d = count_q - (PtrW + 1)'(1);
         default: ;
      endcase
   end

   // Pointers and occupancy; pointers wrap naturally since Depth is a power of 2.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_d;
      end
   end

   // Storage is not reset; contents are ignored while count is zero.
   always_ff @(posedge clk_i) begin
      if (push_en) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/sw_rr_fifo.sv
// sw_rr_fifo: clause switch from carb and NUM_ENG engines into a buffered clq output.
// At most one clause is accepted per cycle: carb first, engines round-robin after it.
// Optional macro SW_STARVE_GUARD_EN adds per-engine starvation counters that let an
// engine stalled for STARVE_MAX consecutive cycles beat carb.
module sw_rr_fifo
   import sw_pkg::*;
#(
   parameter int unsigned NUM_ENG    = SW_DEF_NUM_ENG,
   parameter int unsigned FIFO_DEPTH = SW_DEF_FIFO_DEPTH,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  cla_t                        carb2sw,
   input  logic                        carb2sw_valid,
   output logic                        sw2carb_stall,
   input  cla_t                        eng2sw [NUM_ENG],
   input  logic [NUM_ENG-1:0]          eng2sw_valid,
   output logic [NUM_ENG-1:0]          sw2eng_stall,
   output cla_t                        sw2clq,
   output logic                        sw2clq_valid,
   input  logic                        clq2sw_ready,
   output logic [$clog2(FIFO_DEPTH):0] sw_count
);

   localparam int unsigned RrW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

   if (NUM_ENG < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       STARVE_MAX < 1) begin : g_bad_params
      $error("sw_rr_fifo: illegal parameter set");
   end

   logic [RrW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [NUM_ENG-1:0] eng_rot, eng_gnt;
   logic               scan_found, starve_hit;
   int unsigned        scan_sel, starve_sel, win_sel;
   logic               carb_gnt, eng_win, push, pop, space, empty, full;
   cla_t               push_data;

   assign sw2clq_valid = ~empty;
   assign pop          = sw2clq_valid & clq2sw_ready;
   assign space        = ~full | pop;
   assign push         = carb_gnt | eng_win;

   // Round-robin scan: rotate valids so bit k is engine (rr_ptr + k) mod NUM_ENG.
   always_comb begin
      eng_rot    = NUM_ENG'({eng2sw_valid, eng2sw_valid} >> rr_ptr_q);
      scan_found = 1'b0;
      scan_sel   = 0;
      for (int k = NUM_ENG - 1; k >= 0; k--) begin
         if (eng_rot[k]) begin
            scan_found = 1'b1;
            scan_sel   = rr_index(32'(rr_ptr_q), k, NUM_ENG);
         end
      end
   end

`ifdef SW_STARVE_GUARD_EN
   localparam int unsigned StW = $clog2(STARVE_MAX + 1);

   logic [StW-1:0] starve_q [NUM_ENG];
   logic [StW-1:0] starve_d [NUM_ENG];

   // Lowest-index valid engine whose counter has saturated.
   always_comb begin
      starve_hit = 1'b0;
      starve_sel = 0;
      for (int i = NUM_ENG - 1; i >= 0; i--) begin
         if (eng2sw_valid[i] && starve_q[i] == StW'(STARVE_MAX)) begin
            starve_hit = 1'b1;
            starve_sel = i;
         end
      end
   end

   // Count consecutive stalled-while-valid cycles, saturating; clear otherwise.
   always_comb begin
      for (int i = 0; i < NUM_ENG; i++) begin
         starve_d[i] = '0;
         if (sw2eng_stall[i]) begin
            starve_d[i] = (starve_q[i] == StW'(STARVE_MAX)) ? starve_q[i]
                                                             : starve_q[i] + StW'(1);
         end
      end
   end

   // Starvation counter state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_ENG; i++) starve_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_ENG; i++) starve_q[i] <= starve_d[i];
      end
   end
`else
   assign starve_hit = 1'b0;
   assign starve_sel = 0;
`endif

   // Single-winner grant, only when the FIFO can take a clause this cycle.
   always_comb begin
      carb_gnt = 1'b0;
      eng_win  = 1'b0;
      win_sel  = starve_hit ? starve_sel : scan_sel;
      if (space) begin
         if (starve_hit)         eng_win  = 1'b1;
         else if (carb2sw_valid) carb_gnt = 1'b1;
         else if (scan_found)    eng_win  = 1'b1;
      end
      for (int i = 0; i < NUM_ENG; i++) eng_gnt[i] = eng_win && (win_sel == i);
      rr_ptr_d = eng_win ? RrW'(rr_index(win_sel, 1, NUM_ENG)) : rr_ptr_q;
   end

   assign sw2carb_stall = carb2sw_valid & ~carb_gnt;
   assign sw2eng_stall  = eng2sw_valid & ~eng_gnt;

   // Select the winning clause for the FIFO write port.
   always_comb begin
      push_data = carb2sw;
      for (int i = 0; i < NUM_ENG; i++) begin
         if (eng_gnt[i]) push_data = eng2sw[i];
      end
   end

   // Round-robin pointer; moves only on engine grants.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rr_ptr_q <= '0;
      else          rr_ptr_q <= rr_ptr_d;
   end

   sw_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clock),
      .rst_ni  (reset_n),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (push_data),
      .dout_o  (sw2clq),
      .empty_o (empty),
      .full_o  (full),
      .count_o (sw_count)
   );

endmodule
